// File: rtl/alu_seq_ctrl.sv
// Fetch/execute control-step sequencer for the Mini SRC datapath.
// Drives every datapath strobe from the current step and the decoded IR fields.
//
// state | meaning
// IDLE  | parked, waiting for run
// T0    | PC to MAR, Z <= PC + 1
// T1    | PC <= Z, start memory read
// T1W   | memory wait state, read held
// T2    | MDR to IR
// T3    | Y <= R[rb], decode / illegal check
// T4    | Z <= Y op R[rc]
// T5    | R[ra] <= ZLO, or LO <= ZLO for mul/div
// T6    | HI <= ZHI (mul/div only)
module alu_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_ADDR_W = 4,
    parameter int OPC_W = 5,
    parameter logic [OPC_W-1:0] ALU_INC = 5'b11111,
    parameter logic [OPC_W-1:0] OPC_RMAX = 5'd11,
    parameter logic [OPC_W-1:0] OPC_MUL = 5'd15,
    parameter logic [OPC_W-1:0] OPC_DIV = 5'd16,
    localparam int NUM_REGS = 2**REG_ADDR_W
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   ir,
    output logic                Pout,
    output logic                MARen,
    output logic                Pen,
    output logic                Read,
    output logic                MDRen,
    output logic                MDROut,
    output logic                IRen,
    output logic                Yen,
    output logic                ZLOen,
    output logic                ZHIen,
    output logic                ZLOout,
    output logic                ZHIout,
    output logic                HIen,
    output logic                LOen,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_en,
    output logic [OPC_W-1:0]    alu_control,
    output logic [3:0]          step,
    output logic                instr_done,
    output logic                illegal
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T1W  = 4'd3,
        T2   = 4'd4,
        T3   = 4'd5,
        T4   = 4'd6,
        T5   = 4'd7,
        T6   = 4'd8
    } state_t;

    localparam int FIELD_LSB = DATA_W - OPC_W - 3*REG_ADDR_W;

    state_t state, state_nxt;

    logic [OPC_W-1:0]      opcode;
    logic [REG_ADDR_W-1:0] ra, rb, rc;
    logic                  is_muldiv, is_r3, is_legal;
    logic                  ir_unused;

    assign opcode = ir[DATA_W-1 -: OPC_W];
    assign ra     = ir[DATA_W-OPC_W-1 -: REG_ADDR_W];
    assign rb     = ir[DATA_W-OPC_W-REG_ADDR_W-1 -: REG_ADDR_W];
    assign rc     = ir[DATA_W-OPC_W-2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign ir_unused = ^ir[FIELD_LSB-1:0];

    assign is_muldiv = (opcode == OPC_MUL) || (opcode == OPC_DIV);
    assign is_r3     = (opcode <= OPC_RMAX);
    assign is_legal  = is_muldiv || is_r3;

    assign step = state;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        Pout        = 1'b0;
        MARen       = 1'b0;
        Pen         = 1'b0;
        Read        = 1'b0;
        MDRen       = 1'b0;
        MDROut      = 1'b0;
        IRen        = 1'b0;
        Yen         = 1'b0;
        ZLOen       = 1'b0;
        ZHIen       = 1'b0;
        ZLOout      = 1'b0;
        ZHIout      = 1'b0;
        HIen        = 1'b0;
        LOen        = 1'b0;
        reg_out     = '0;
        reg_en      = '0;
        alu_control = '0;
        instr_done  = 1'b0;
        illegal     = 1'b0;

        case (state)
            IDLE: begin
                if (run) state_nxt = T0;
            end
            T0: begin
                Pout        = 1'b1;
                MARen       = 1'b1;
                ZLOen       = 1'b1;
                alu_control = ALU_INC;
                state_nxt   = T1;
            end
            T1: begin
                ZLOout    = 1'b1;
                Pen       = 1'b1;
                Read      = 1'b1;
                MDRen     = 1'b1;
                state_nxt = mem_ready ? T2 : T1W;
            end
            // PC already advanced in T1, so only the read is held here.
            T1W: begin
                Read  = 1'b1;
                MDRen = 1'b1;
                if (mem_ready) state_nxt = T2;
            end
            T2: begin
                MDROut    = 1'b1;
                IRen      = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                reg_out = NUM_REGS'(1) << rb;
                Yen     = 1'b1;
                if (!is_legal) begin
                    illegal   = 1'b1;
                    state_nxt = run ? T0 : IDLE;
                end else begin
                    state_nxt = T4;
                end
            end
            T4: begin
                reg_out     = NUM_REGS'(1) << rc;
                alu_control = opcode;
                ZLOen       = 1'b1;
                ZHIen       = is_muldiv;
                state_nxt   = T5;
            end
            T5: begin
                ZLOout = 1'b1;
                if (is_muldiv) begin
                    LOen      = 1'b1;
                    state_nxt = T6;
                end else begin
                    reg_en     = NUM_REGS'(1) << ra;
                    instr_done = 1'b1;
                    state_nxt  = run ? T0 : IDLE;
                end
            end
            T6: begin
                ZHIout     = 1'b1;
                HIen       = 1'b1;
                instr_done = 1'b1;
                state_nxt  = run ? T0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
